// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//   Receive-side buffer placed directly after a UART receiver. A small
//   capture FSM takes each completed byte from the receiver's level-style
//   data/ready pair, pushes it into a circular FIFO and returns a one-cycle
//   acknowledge that clears the receiver's ready flag. The consumer sees a
//   first-word-fall-through read port and a sticky overrun flag.
//
//   Optional feature macro: UART_RX_FIFO_AFULL_EN
//     When defined, the o_almost_full port exists and asserts while
//     count >= AFULL_LEVEL. When undefined the port and its logic are absent.
//
// Ports
//   i_clk          system clock, all state on rising edge
//   i_reset        asynchronous reset, active low (0 = reset asserted)
//   i_rx_data      byte from receiver, valid while i_rx_ready = 1
//   i_rx_ready     receiver byte-available level, held until acknowledged
//   o_rx_ack       one-cycle pulse to the receiver's ready-clear input
//   i_rd_en        consumer pop request
//   o_rd_data      head entry (FWFT); content undefined while empty
//   o_empty        FIFO holds 0 entries
//   o_full         FIFO holds 2**DEPTH_LOG2 entries
//   o_count        current occupancy, 0 .. 2**DEPTH_LOG2
//   o_overrun      sticky: a byte arrived while full and was dropped
//   i_clr_overrun  synchronous clear of o_overrun (a same-cycle set wins)
//   o_almost_full  count >= AFULL_LEVEL (UART_RX_FIFO_AFULL_EN only)
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned DEPTH_LOG2  = 4,
  parameter int unsigned AFULL_LEVEL = 12
) (
  input  logic                  i_clk,
`ifdef UART_RX_FIFO_AFULL_EN
  output logic                  o_almost_full,
`endif
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic                  i_rx_ready,
  output logic                  o_rx_ack,
  input  logic                  i_rd_en,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_empty,
  output logic                  o_full,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_overrun,
  input  logic                  i_clr_overrun
);

  localparam int unsigned PTR_W = DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // Capture FSM states; the fourth encoding is unused and recovers to idle.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACK   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_rx_ack;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_overrun;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic w_empty;
  logic w_full;
  logic w_capture;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // Occupancy flags decoded from the registered count.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_FULL);

  // A byte is sampled only in idle; the ack/drain states block re-capture
  // of the same byte while the receiver is still clearing its ready flag.
  assign w_capture = (r_state == S_IDLE) && i_rx_ready;

  // Pops on an empty FIFO are silently ignored.
  assign w_pop = i_rd_en && !w_empty;

  // When full, a same-cycle pop frees the slot the new byte goes into.
  assign w_push = w_capture && (!w_full || i_rd_en);
  assign w_drop = w_capture && w_full && !i_rd_en;

  // Capture FSM, pointers, occupancy and overrun flag.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= S_IDLE;
      r_rx_ack  <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_rx_ack <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (i_rx_ready) begin
            r_state  <= S_ACK;
            r_rx_ack <= 1'b1;
          end
        end
        S_ACK: begin
          r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!i_rx_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      // Pointers wrap through natural PTR_W-bit overflow.
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase

      // Set has priority over a same-cycle clear.
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (i_clr_overrun) begin
        r_overrun <= 1'b0;
      end
    end
  end

  // Storage array; contents are intentionally not reset.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_rx_data;
    end
  end

  assign o_rx_ack  = r_rx_ack;
  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_empty   = w_empty;
  assign o_full    = w_full;
  assign o_count   = r_count;
  assign o_overrun = r_overrun;

`ifdef UART_RX_FIFO_AFULL_EN
  assign o_almost_full = (r_count >= CNT_W'(AFULL_LEVEL));
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
//   Self-checking bench for uart_rx_fifo: a per-cycle vector table for the
//   basic handshake/empty-read behaviour, plus hand-written sequences for
//   overrun, full-with-simultaneous-pop, almost_full and mid-handshake reset.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_ack;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overrun;
  logic       clr_overrun;
`ifdef UART_RX_FIFO_AFULL_EN
  logic       almost_full;
`endif

  int errors = 0;
  int checks = 0;

  uart_rx_fifo #(
    .DATA_WIDTH (8),
    .DEPTH_LOG2 (4),
    .AFULL_LEVEL(12)
  ) dut (
    .i_clk        (clk),
`ifdef UART_RX_FIFO_AFULL_EN
    .o_almost_full(almost_full),
`endif
    .i_reset      (reset),
    .i_rx_data    (rx_data),
    .i_rx_ready   (rx_ready),
    .o_rx_ack     (rx_ack),
    .i_rd_en      (rd_en),
    .o_rd_data    (rd_data),
    .o_empty      (empty),
    .o_full       (full),
    .o_count      (count),
    .o_overrun    (overrun),
    .i_clr_overrun(clr_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rd_en;
    logic       clr;
    logic       exp_ack;
    logic       exp_empty;
    logic       exp_full;
    logic [4:0] exp_count;
    logic       exp_ovr;
    logic       chk_data;
    logic [7:0] exp_data;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic rdy, input logic [7:0] d, input logic rd,
                              input logic ack, input logic emp, input logic [4:0] cnt,
                              input logic chk, input logic [7:0] ed);
    vec_t v;
    v.rx_ready  = rdy;
    v.rx_data   = d;
    v.rd_en     = rd;
    v.clr       = 1'b0;
    v.exp_ack   = ack;
    v.exp_empty = emp;
    v.exp_full  = 1'b0;
    v.exp_count = cnt;
    v.exp_ovr   = 1'b0;
    v.chk_data  = chk;
    v.exp_data  = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One capture handshake; receiver drops ready right after the ack pulse.
  task automatic push(input logic [7:0] d, input logic rd, input logic clr);
    @(negedge clk);
    rx_ready    = 1'b1;
    rx_data     = d;
    rd_en       = rd;
    clr_overrun = clr;
    @(posedge clk); #1;
    chk("push_ack_high", 32'(rx_ack), 32'd1);
    @(negedge clk);
    rx_ready    = 1'b0;
    rd_en       = 1'b0;
    clr_overrun = 1'b0;
    @(posedge clk); #1;
    chk("push_ack_low", 32'(rx_ack), 32'd0);
    @(posedge clk); #1;
  endtask

  // Verify the head word, then pop it.
  task automatic pop_check(input logic [7:0] exp);
    @(negedge clk);
    chk("pop_head_data", 32'(rd_data), 32'(exp));
    chk("pop_not_empty", 32'(empty), 32'd0);
    rd_en = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    reset       = 1'b0;
    rx_data     = 8'h00;
    rx_ready    = 1'b0;
    rd_en       = 1'b0;
    clr_overrun = 1'b0;

    // Handshake, slow ready clear, empty reads, re-push.
    vecs[0] = mk(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 5'd1, 1'b1, 8'hA5);
    for (int i = 1; i <= 10; i++) vecs[i] = mk(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 8'hA5);
    vecs[11] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 8'hA5);
    vecs[12] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 8'h00);
    for (int i = 13; i <= 17; i++) vecs[i] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 8'h00);
    vecs[18] = mk(1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 5'd1, 1'b1, 8'h3C);
    vecs[19] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 8'h3C);
    vecs[20] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 8'h3C);
    vecs[21] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 8'h00);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 32'(rx_ack), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      rx_ready    = vecs[i].rx_ready;
      rx_data     = vecs[i].rx_data;
      rd_en       = vecs[i].rd_en;
      clr_overrun = vecs[i].clr;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_ack", i), 32'(rx_ack), 32'(vecs[i].exp_ack));
      chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].exp_empty));
      chk($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].exp_full));
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
      chk($sformatf("vec%0d_overrun", i), 32'(overrun), 32'(vecs[i].exp_ovr));
      if (vecs[i].chk_data) chk($sformatf("vec%0d_data", i), 32'(rd_data), 32'(vecs[i].exp_data));
    end
    @(negedge clk);
    rx_ready = 1'b0;
    rd_en    = 1'b0;

    // Fill, overflow, sticky overrun with set-beats-clear, drain in order.
    for (int i = 0; i < 16; i++) push(8'(i), 1'b0, 1'b0);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd16);
    chk("fill_overrun", 32'(overrun), 32'd0);
    push(8'hFF, 1'b0, 1'b0);
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_count", 32'(count), 32'd16);
    push(8'hEE, 1'b0, 1'b1);
    chk("ovr_set_wins", 32'(overrun), 32'd1);
    chk("ovr_count2", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) pop_check(8'(i));
    #1;
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_ovr_sticky", 32'(overrun), 32'd1);
    clr_overrun = 1'b1;
    @(posedge clk); #1;
    chk("ovr_cleared", 32'(overrun), 32'd0);
    @(negedge clk);
    clr_overrun = 1'b0;

    // Full with simultaneous pop: byte accepted, no overrun.
    for (int i = 0; i < 16; i++) push(8'(8'h10 + i), 1'b0, 1'b0);
    chk("full2_count", 32'(count), 32'd16);
    push(8'h55, 1'b1, 1'b0);
    chk("fullpop_count", 32'(count), 32'd16);
    chk("fullpop_overrun", 32'(overrun), 32'd0);
    chk("fullpop_full", 32'(full), 32'd1);
    for (int i = 1; i < 16; i++) pop_check(8'(8'h10 + i));
    pop_check(8'h55);
    #1;
    chk("fullpop_empty", 32'(empty), 32'd1);

`ifdef UART_RX_FIFO_AFULL_EN
    for (int i = 0; i < 11; i++) push(8'(8'h80 + i), 1'b0, 1'b0);
    chk("afull_11", 32'(almost_full), 32'd0);
    push(8'h8B, 1'b0, 1'b0);
    chk("afull_12", 32'(almost_full), 32'd1);
    pop_check(8'h80);
    #1;
    chk("afull_pop", 32'(almost_full), 32'd0);
    for (int i = 1; i < 12; i++) pop_check(8'(8'h80 + i));
    #1;
    chk("afull_empty", 32'(empty), 32'd1);
`endif

    // Reset while in the ack state; ready still high afterwards is recaptured.
    @(negedge clk);
    rx_ready = 1'b1;
    rx_data  = 8'h77;
    @(posedge clk); #1;
    chk("midrst_pre_ack", 32'(rx_ack), 32'd1);
    chk("midrst_pre_count", 32'(count), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("midrst_ack", 32'(rx_ack), 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_empty", 32'(empty), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("recap_ack", 32'(rx_ack), 32'd1);
    chk("recap_count", 32'(count), 32'd1);
    chk("recap_data", 32'(rd_data), 32'h77);
    @(negedge clk);
    rx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("recap_single", 32'(count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer that sits directly downstream of the UART receiver.
- Takes each completed byte from the receiver's data/ready pair and pushes it into a circular FIFO.
- Acknowledges the byte back to the receiver through a one-cycle pulse on its ready-clear input.
- Presents a first-word-fall-through read port to the consumer logic, plus sticky overrun reporting.

Parameters:
DATA_WIDTH, 8, width of one received word (matches receiver data output)
DEPTH_LOG2, 4, log2 of FIFO depth; depth = 2**DEPTH_LOG2 entries (default 16)
AFULL_LEVEL, 12, count at or above which almost_full asserts (only with optional feature)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset; 0 = reset asserted
rx_data  input  DATA_WIDTH  byte from receiver, valid while rx_ready=1
rx_ready  input  1  receiver "byte available" flag (level, held until cleared)
rx_ack  output  1  one-cycle pulse to receiver's reset_ready; clears rx_ready
rd_en  input  1  consumer pop request
rd_data  output  DATA_WIDTH  head entry (FWFT); undefined content when empty
empty  output  1  FIFO holds 0 entries
full  output  1  FIFO holds 2**DEPTH_LOG2 entries
count  output  DEPTH_LOG2+1  current occupancy, 0..2**DEPTH_LOG2
overrun  output  1  sticky: a byte arrived while full and was dropped
clr_overrun  input  1  synchronous clear of overrun
almost_full  output  1  count >= AFULL_LEVEL (present only with UART_RX_FIFO_AFULL_EN)

Behaviour:
- Reset (reset=0, async):
  - wr_ptr=0, rd_ptr=0, count=0; empty=1, full=0, overrun=0, rx_ack=0.
  - FSM to sIdle; memory contents not cleared.
- Capture FSM, 2-bit, registered:
  - sIdle: if rx_ready=1, take the push decision on this edge and go to sAck; else stay.
  - sAck: rx_ack=1 for exactly this one cycle; go to sDrain.
  - sDrain: rx_ack=0; stay until rx_ready=0, then go to sIdle. This prevents double-capture of one byte while the receiver clears ready.
  - Unused encoding goes to sIdle.
- Push decision (sIdle with rx_ready=1):
  - Accepted if full=0, or full=1 and rd_en=1 in the same cycle.
  - Otherwise the byte is dropped and overrun is set.
  - rx_ack is issued in both cases.
- Write: mem[wr_ptr]<=rx_data; wr_ptr<=wr_ptr+1, wrapping modulo depth via natural DEPTH_LOG2-bit overflow.
- Read:
  - rd_data = mem[rd_ptr] combinationally.
  - rd_en=1 with empty=0 advances rd_ptr by one, with wrap.
  - rd_en=1 with empty=1 is ignored: no pointer or count change, no error flag.
- Count:
  - +1 on accepted push only; -1 on valid pop only; unchanged when both occur in the same cycle.
  - Never exceeds depth, never underflows.
  - full and empty are decoded from count.
- Latency:
  - Byte visible on rd_data and empty=0 one cycle after the sIdle edge where rx_ready was seen.
  - rx_ack asserts in that same following cycle.
- Overrun:
  - Set on a dropped byte; cleared by clr_overrun=1.
  - A set and a clear in the same cycle leave it set, because set wins.
- Reset mid-handshake: FSM returns to sIdle immediately. A receiver still holding rx_ready=1 after reset release is captured again; this is intended.

Optional Feature:
- Macro: UART_RX_FIFO_AFULL_EN.
- Defined:
  - almost_full port exists; almost_full = (count >= AFULL_LEVEL), combinational from registered count.
  - Reset value 0.
- Not defined:
  - almost_full port and AFULL_LEVEL logic are absent.
  - All other behaviour is identical.

Test Plan:
- Reset=0, then release; hold rx_ready=1 with rx_data=8'hA5 until ack → one rx_ack pulse, count=1, rd_data=8'hA5, empty=0.
- rx_ready held high for 10 cycles after ack (slow clear) → exactly one entry pushed, count stays 1.
- Push 16 bytes 8'h00..8'h0F, then push 8'hFF with rd_en=0 → full=1, count=16, overrun=1, 8'hFF dropped, rx_ack still pulsed. Then pop all 16 → rd_data sequence 00..0F, then empty=1.
- With count=16, push 8'h55 and assert rd_en in the same cycle → accepted, count=16, overrun=0. After 16 further pops, last word read is 8'h55.
- rd_en=1 for 5 cycles while empty → count=0, rd_ptr unchanged; a subsequent push of 8'h3C reads back 8'h3C.
- UART_RX_FIFO_AFULL_EN defined, AFULL_LEVEL=12: push 11 bytes → almost_full=0; push the 12th → almost_full=1; pop one → almost_full=0. Also assert reset mid-sAck → rx_ack=0, count=0 at once.
